alu: RTL and testbench

8-bit two-operand arithmetic/logic unit for the SnailArch datapath. It computes one of 16 operations on operands `A` and `B` selected by `op`. The result `E` and the 2-bit condition code `cc` are registered, so both appear one clock after the operands are sampled. The register file/control unit drives the inputs; `E` feeds write-back and `cc` feeds branch logic.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_shifter.sv | 60 ++++++
 rtl/alu.sv | 124 ++++++++++++
 tb/tb_alu.sv | 103 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the SnailArch 8-bit ALU: opcode encoding,
// condition-code bit positions and shifter mode encoding.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int CC_C  = 1;
    localparam int CC_Z  = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SAR  = 4'd8,
        OP_ROL  = 4'd9,
        OP_ROR  = 4'd10,
        OP_INC  = 4'd11,
        OP_DEC  = 4'd12,
        OP_NEG  = 4'd13,
        OP_MOVB = 4'd14,
        OP_CMP  = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        SH_SHL = 3'd0,
        SH_SHR = 3'd1,
        SH_SAR = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit. A zero amount passes the operand through
// and reports no shift-out bit.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [2:0]       amount,
    input  shift_mode_e      mode,
    output logic [ALU_W-1:0] result,
    output logic             shout
);

    logic [2*ALU_W-1:0] wide_s;
    logic               shout_raw_s;

    // Shift within a double-width word so the last bit out lands at a fixed position
    always_comb begin
        wide_s      = 16'd0;
        result      = a;
        shout_raw_s = 1'b0;
        case (mode)
            SH_SHL: begin
                wide_s      = {8'd0, a} << amount;
                result      = wide_s[7:0];
                shout_raw_s = wide_s[8];
            end
            SH_SHR: begin
                wide_s      = {a, 8'd0} >> amount;
                result      = wide_s[15:8];
                shout_raw_s = wide_s[7];
            end
            SH_SAR: begin
                wide_s      = $signed({a, 8'd0}) >>> amount;
                result      = wide_s[15:8];
                shout_raw_s = wide_s[7];
            end
            SH_ROL: begin
                wide_s      = {a, a} << amount;
                result      = wide_s[15:8];
                shout_raw_s = wide_s[8];
            end
            SH_ROR: begin
                wide_s      = {a, a} >> amount;
                result      = wide_s[7:0];
                shout_raw_s = wide_s[7];
            end
            default: begin
                wide_s      = 16'd0;
                result      = a;
                shout_raw_s = 1'b0;
            end
        endcase
    end

    // Rotates by zero would otherwise report a bit of A as carry
    always_comb begin
        shout = shout_raw_s & (amount != 3'd0);
    end

endmodule

// File: rtl/alu.sv
// SnailArch 8-bit ALU: 16 operations, result and condition code registered
// one clock after the operands are sampled.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] E,
    output logic [1:0]       cc
);

    op_e              op_s;
    logic [ALU_W-1:0] arith_a_s;
    logic [ALU_W-1:0] arith_b_s;
    logic             arith_sub_s;
    logic [ALU_W:0]   arith_s;
    shift_mode_e      shift_mode_s;
    logic [ALU_W-1:0] shift_res_s;
    logic             shift_out_s;
    logic [ALU_W-1:0] result_s;
    logic             carry_s;
    logic             zero_s;
    logic             write_e_s;
    logic [ALU_W-1:0] e_r;
    logic [1:0]       cc_r;

    assign op_s = op_e'(op);

    // Operand steering for the shared adder and the shifter mode
    always_comb begin
        arith_a_s    = A;
        arith_b_s    = B;
        arith_sub_s  = 1'b0;
        shift_mode_s = SH_SHL;
        case (op_s)
            OP_SUB, OP_CMP: arith_sub_s = 1'b1;
            OP_INC: arith_b_s = 8'd1;
            OP_DEC: begin
                arith_b_s   = 8'd1;
                arith_sub_s = 1'b1;
            end
            OP_NEG: begin
                arith_a_s   = 8'd0;
                arith_b_s   = A;
                arith_sub_s = 1'b1;
            end
            OP_SHR: shift_mode_s = SH_SHR;
            OP_SAR: shift_mode_s = SH_SAR;
            OP_ROL: shift_mode_s = SH_ROL;
            OP_ROR: shift_mode_s = SH_ROR;
            default: begin
                arith_a_s    = A;
                arith_b_s    = B;
                arith_sub_s  = 1'b0;
                shift_mode_s = SH_SHL;
            end
        endcase
    end

    // Bit 8 is carry for additions and borrow for subtractions
    assign arith_s = arith_sub_s ? ({1'b0, arith_a_s} - {1'b0, arith_b_s})
                                 : ({1'b0, arith_a_s} + {1'b0, arith_b_s});

    alu_shifter u_shifter (
        .a      (A),
        .amount (B[2:0]),
        .mode   (shift_mode_s),
        .result (shift_res_s),
        .shout  (shift_out_s)
    );

    // Result and carry selection
    always_comb begin
        result_s  = arith_s[ALU_W-1:0];
        carry_s   = 1'b0;
        write_e_s = 1'b1;
        case (op_s)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: carry_s = arith_s[ALU_W];
            OP_CMP: begin
                carry_s   = arith_s[ALU_W];
                write_e_s = 1'b0;
            end
            OP_AND:  result_s = A & B;
            OP_OR:   result_s = A | B;
            OP_XOR:  result_s = A ^ B;
            OP_NOT:  result_s = ~A;
            OP_MOVB: result_s = B;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                result_s = shift_res_s;
                carry_s  = shift_out_s;
            end
            default: begin
                result_s  = arith_s[ALU_W-1:0];
                carry_s   = 1'b0;
                write_e_s = 1'b1;
            end
        endcase
    end

    assign zero_s = (result_s == 8'd0);

    // Output registers; CMP updates flags only
    always_ff @(posedge clk) begin
        if (rst) begin
            e_r  <= 8'd0;
            cc_r <= 2'b00;
        end else begin
            if (write_e_s) begin
                e_r <= result_s;
            end else begin
                e_r <= e_r;
            end
            cc_r[CC_C] <= carry_s;
            cc_r[CC_Z] <= zero_s;
        end
    end

    assign E  = e_r;
    assign cc = cc_r;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu: reset, every opcode class,
// shift boundaries, CMP hold behaviour and mid-stream reset.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] op;
    logic [7:0] E;
    logic [1:0] cc;

    int checks_total;
    int checks_passed;

    alu dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .op  (op),
        .E   (E),
        .cc  (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got E=%02h cc=%02b, expected E=%02h cc=%02b",
                     tag, got[9:2], got[1:0], exp[9:2], exp[1:0]);
        end
    endtask

    // Drive one set of inputs, take one edge, then compare just after it
    task automatic step(input string tag, input logic r, input logic [3:0] o,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_e, input logic [1:0] exp_cc);
        rst = r;
        op  = o;
        A   = a;
        B   = b;
        @(posedge clk);
        #1;
        check(tag, {E, cc}, {exp_e, exp_cc});
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1;
        A   = 8'h00;
        B   = 8'h00;
        op  = 4'd0;
        @(negedge clk);

        step("reset",      1'b1, 4'd0,  8'h55, 8'hAA, 8'h00, 2'b00);
        step("post_reset", 1'b0, 4'd0,  8'h55, 8'hAA, 8'hFF, 2'b00);
        step("add_small",  1'b0, 4'd0,  8'h01, 8'h02, 8'h03, 2'b00);
        step("add_wrap",   1'b0, 4'd0,  8'hFF, 8'h01, 8'h00, 2'b11);
        step("sub_borrow", 1'b0, 4'd1,  8'h10, 8'h20, 8'hF0, 2'b10);
        step("cmp_equal",  1'b0, 4'd15, 8'h33, 8'h33, 8'hF0, 2'b01);
        step("cmp_less",   1'b0, 4'd15, 8'h10, 8'h20, 8'hF0, 2'b10);
        step("shl_1",      1'b0, 4'd6,  8'h81, 8'h01, 8'h02, 2'b10);
        step("sar_1",      1'b0, 4'd8,  8'h81, 8'h01, 8'hC0, 2'b10);
        step("rol_1",      1'b0, 4'd9,  8'h81, 8'h01, 8'h03, 2'b10);
        step("shr_0",      1'b0, 4'd7,  8'h81, 8'h00, 8'h81, 2'b00);
        step("rol_0",      1'b0, 4'd9,  8'h81, 8'hF8, 8'h81, 2'b00);
        step("shr_1",      1'b0, 4'd7,  8'h03, 8'h01, 8'h01, 2'b10);
        step("ror_1",      1'b0, 4'd10, 8'h01, 8'h01, 8'h80, 2'b10);
        step("shl_7",      1'b0, 4'd6,  8'h03, 8'h07, 8'h80, 2'b10);
        step("sar_7",      1'b0, 4'd8,  8'h80, 8'h07, 8'hFF, 2'b00);
        step("dec_zero",   1'b0, 4'd12, 8'h00, 8'h00, 8'hFF, 2'b10);
        step("neg_zero",   1'b0, 4'd13, 8'h00, 8'h00, 8'h00, 2'b01);
        step("neg_one",    1'b0, 4'd13, 8'h01, 8'h00, 8'hFF, 2'b10);
        step("inc_ff",     1'b0, 4'd11, 8'hFF, 8'h00, 8'h00, 2'b11);
        step("and",        1'b0, 4'd2,  8'hF0, 8'h3C, 8'h30, 2'b00);
        step("or",         1'b0, 4'd3,  8'h0F, 8'hF0, 8'hFF, 2'b00);
        step("xor_zero",   1'b0, 4'd4,  8'hAA, 8'hAA, 8'h00, 2'b01);
        step("not",        1'b0, 4'd5,  8'h0F, 8'h00, 8'hF0, 2'b00);
        step("movb",       1'b0, 4'd14, 8'h12, 8'h5A, 8'h5A, 2'b00);

        // Inputs changed between edges must not disturb the held outputs
        A  = 8'hFF;
        B  = 8'hFF;
        op = 4'd0;
        #3;
        check("hold_between_edges", {E, cc}, {8'h5A, 2'b00});

        step("mid_add",    1'b0, 4'd0,  8'h40, 8'h40, 8'h80, 2'b00);
        step("mid_reset",  1'b1, 4'd0,  8'h01, 8'h01, 8'h00, 2'b00);
        step("cmp_after_reset", 1'b0, 4'd15, 8'h05, 8'h09, 8'h00, 2'b10);
        step("sub_after",  1'b0, 4'd1,  8'h09, 8'h05, 8'h04, 2'b00);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
